// File: rtl/sdram_pkg.sv
`default_nettype none
// =============================================================================
// Package  : sdram_pkg
// Brief    : Shared encodings for the SDRAM arbiter and refresh timer:
//            core command codes, arbiter state encoding, default refresh period.
// Revision : 1.0 - initial release
// =============================================================================
package sdram_pkg;

    // Command codes presented to the SDRAM command core
    localparam logic [1:0] CMD_NOP = 2'd0;
    localparam logic [1:0] CMD_REF = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_RD  = 2'd3;

    // Arbiter states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BURST   = 2'd2,
        ST_REFWAIT = 2'd3
    } state_t;

    // 7.8 us between refreshes at 100 MHz
    localparam int unsigned c_REFRESH_PERIOD = 780;

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// =============================================================================
// Interface : sdram_arbiter_if
// Brief     : Requester flags, SDRAM core command handshake and arbiter status.
//             master = arbiter side, slave = requesters/core side.
// Revision  : 1.0 - initial release
// =============================================================================
interface sdram_arbiter_if;
    logic       enable;
    logic       wr_req;
    logic       rd_req;
    logic       rd_blocked;
    logic       rd_prio;
    logic       core_valid;
    logic [1:0] core_cmd;
    logic       core_ready;
    logic       core_word;
    logic       core_stop;
    logic       core_done;
    logic       wr_grant;
    logic       rd_grant;
    logic [1:0] ref_debt;
    logic       ref_overrun;

    modport master (
        input  enable, wr_req, rd_req, rd_blocked, rd_prio,
        input  core_ready, core_word, core_done,
        output core_valid, core_cmd, core_stop,
        output wr_grant, rd_grant, ref_debt, ref_overrun
    );

    modport slave (
        output enable, wr_req, rd_req, rd_blocked, rd_prio,
        output core_ready, core_word, core_done,
        input  core_valid, core_cmd, core_stop,
        input  wr_grant, rd_grant, ref_debt, ref_overrun
    );
endinterface
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// =============================================================================
// Module   : sdram_refresh_timer
// Brief    : Periodic refresh tick generator with a saturating 2-bit debt
//            counter and a sticky overrun flag.
// Revision : 1.0 - initial release
// =============================================================================
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int unsigned REFRESH_PERIOD = c_REFRESH_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ref_done,
    output logic [1:0] ref_debt,
    output logic       ref_overrun
);

    localparam int unsigned          c_TMR_W  = $clog2(REFRESH_PERIOD);
    localparam logic [c_TMR_W-1:0]   c_RELOAD = c_TMR_W'(REFRESH_PERIOD - 1);

    logic [c_TMR_W-1:0] r_timer;
    logic [1:0]         r_debt;
    logic               r_overrun;
    logic               w_tick;

    assign w_tick      = enable && (r_timer == '0);
    assign ref_debt    = r_debt;
    assign ref_overrun = r_overrun;

    // Down-counter: parked at reload while disabled, reloads on every tick
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_timer <= c_RELOAD;
        end else if (w_tick) begin
            r_timer <= c_RELOAD;
        end else begin
            r_timer <= r_timer - c_TMR_W'(1);
        end
    end

    // Debt: +1 per tick (saturating), -1 per finished refresh; both cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_debt    <= 2'd0;
            r_overrun <= 1'b0;
        end else begin
            if (!enable) begin
                r_debt <= 2'd0;
            end else if (w_tick && !ref_done) begin
                if (r_debt != 2'd3) begin
                    r_debt <= r_debt + 2'd1;
                end
            end else if (ref_done && !w_tick) begin
                if (r_debt != 2'd0) begin
                    r_debt <= r_debt - 2'd1;
                end
            end
            if (w_tick && (r_debt == 2'd3)) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : sdram_arbiter
// Brief    : Time-sliced scheduler for the single SDRAM port. Arbitrates
//            refresh, sample-write and readback bursts, bounds bursts to a
//            word quantum and asks the core to stop when refresh is owed.
// Revision : 1.0 - initial release
// =============================================================================
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned REFRESH_PERIOD = c_REFRESH_PERIOD,
    parameter int unsigned QUANTUM        = 64,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic            clk,
    input  logic            rst,
    sdram_arbiter_if.master bus
);

    localparam int unsigned         c_WCNT_W   = $clog2(QUANTUM + 1);
    localparam int unsigned         c_SKIP_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_WCNT_W-1:0] c_LAST     = c_WCNT_W'(QUANTUM - 1);
    localparam logic [c_SKIP_W-1:0] c_SKIP_MAX = c_SKIP_W'(STARVE_LIMIT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_cmd;
    logic                r_wr_grant;
    logic                r_rd_grant;
    logic                r_stop;
    logic [c_WCNT_W-1:0] r_word_cnt;
    logic [c_SKIP_W-1:0] r_skip_cnt;
    logic                w_sel;
    logic [1:0]          w_sel_cmd;
    logic                w_skip_inc;
    logic                w_rd_elig;
    logic                w_handshake;
    logic                w_ref_done;
    logic [1:0]          w_ref_debt;

    assign w_rd_elig   = bus.rd_req && !bus.rd_blocked;
    assign w_handshake = (r_state == ST_ISSUE) && bus.core_ready;
    assign w_ref_done  = (r_state == ST_REFWAIT) && bus.core_done;

    sdram_refresh_timer #(
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (bus.enable),
        .ref_done    (w_ref_done),
        .ref_debt    (w_ref_debt),
        .ref_overrun (bus.ref_overrun)
    );

    assign bus.core_valid = (r_state == ST_ISSUE);
    assign bus.core_cmd   = r_cmd;
    assign bus.core_stop  = r_stop;
    assign bus.wr_grant   = r_wr_grant;
    assign bus.rd_grant   = r_rd_grant;
    assign bus.ref_debt   = w_ref_debt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and IDLE selection: refresh first, then read/write with starvation guard
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = 1'b0;
        w_sel_cmd   = CMD_NOP;
        w_skip_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    if (w_ref_debt != 2'd0) begin
                        w_sel     = 1'b1;
                        w_sel_cmd = CMD_REF;
                    end else if (w_rd_elig && bus.wr_req) begin
                        w_sel = 1'b1;
                        if (bus.rd_prio || (r_skip_cnt == c_SKIP_MAX)) begin
                            w_sel_cmd = CMD_RD;
                        end else begin
                            w_sel_cmd  = CMD_WR;
                            w_skip_inc = 1'b1;
                        end
                    end else if (w_rd_elig) begin
                        w_sel     = 1'b1;
                        w_sel_cmd = CMD_RD;
                    end else if (bus.wr_req) begin
                        w_sel     = 1'b1;
                        w_sel_cmd = CMD_WR;
                    end
                end
                if (w_sel) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.core_ready) begin
                    w_state_nxt = (r_cmd == CMD_REF) ? ST_REFWAIT : ST_BURST;
                end
            end
            ST_BURST, ST_REFWAIT: begin
                if (bus.core_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the selected command and track how often a read lost contention
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= CMD_NOP;
            r_skip_cnt <= '0;
        end else if (w_sel) begin
            r_cmd <= w_sel_cmd;
            if (w_sel_cmd == CMD_RD) begin
                r_skip_cnt <= '0;
            end else if (w_skip_inc) begin
                r_skip_cnt <= r_skip_cnt + c_SKIP_W'(1);
            end
        end
    end

    // Burst bookkeeping: grant flags, word quantum and the registered stop request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_grant <= 1'b0;
            r_rd_grant <= 1'b0;
            r_stop     <= 1'b0;
            r_word_cnt <= '0;
        end else if (w_handshake && (r_cmd != CMD_REF)) begin
            r_wr_grant <= (r_cmd == CMD_WR);
            r_rd_grant <= (r_cmd == CMD_RD);
            r_word_cnt <= '0;
        end else if (r_state == ST_BURST) begin
            if (bus.core_done) begin
                r_wr_grant <= 1'b0;
                r_rd_grant <= 1'b0;
                r_stop     <= 1'b0;
            end else begin
                if (bus.core_word) begin
                    r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
                end
                if ((bus.core_word && (r_word_cnt == c_LAST)) ||
                    (w_ref_debt != 2'd0) || !bus.enable) begin
                    r_stop <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_sdram_arbiter
// Brief    : Directed self-checking bench for sdram_arbiter with
//            REFRESH_PERIOD=16, QUANTUM=8, STARVE_LIMIT=4.
// Revision : 1.0 - initial release
// =============================================================================
module tb_sdram_arbiter;
    import sdram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk_cnt = 0;
    int   err_cnt = 0;

    sdram_arbiter_if bus ();

    sdram_arbiter #(
        .REFRESH_PERIOD (16),
        .QUANTUM        (8),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle before sampling or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reset for two edges with every input idle; timer restarts from reload
    task automatic start();
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.wr_req     = 1'b0;
        bus.rd_req     = 1'b0;
        bus.rd_blocked = 1'b0;
        bus.rd_prio    = 1'b0;
        bus.core_ready = 1'b0;
        bus.core_word  = 1'b0;
        bus.core_done  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Wait for an offer, check its command, accept it, then finish it at once
    task automatic run_op(input logic [1:0] exp_cmd, input string tag);
        int n = 0;
        while (!bus.core_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.core_valid), 1);
        chk({tag, "_cmd"}, 32'(bus.core_cmd), 32'(exp_cmd));
        bus.core_ready = 1'b1;
        step();
        bus.core_ready = 1'b0;
        chk({tag, "_wrg"}, 32'(bus.wr_grant), (exp_cmd == CMD_WR) ? 1 : 0);
        chk({tag, "_rdg"}, 32'(bus.rd_grant), (exp_cmd == CMD_RD) ? 1 : 0);
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        chk({tag, "_clr"}, 32'({bus.wr_grant, bus.rd_grant}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int refs;
        int hs;
        int stop_seen;

        // ---------------- reset values and first refresh ----------------
        start();
        chk("rst_valid",   32'(bus.core_valid), 0);
        chk("rst_cmd",     32'(bus.core_cmd), 0);
        chk("rst_stop",    32'(bus.core_stop), 0);
        chk("rst_grants",  32'({bus.wr_grant, bus.rd_grant}), 0);
        chk("rst_debt",    32'(bus.ref_debt), 0);
        chk("rst_overrun", 32'(bus.ref_overrun), 0);
        bus.enable = 1'b1;
        repeat (15) step();
        chk("ref_pre_tick", 32'(bus.ref_debt), 0);
        step();
        chk("ref_tick_debt",  32'(bus.ref_debt), 1);
        chk("ref_tick_valid", 32'(bus.core_valid), 0);
        step();
        chk("ref_issue_valid", 32'(bus.core_valid), 1);
        chk("ref_issue_cmd",   32'(bus.core_cmd), 32'(CMD_REF));
        step();
        chk("ref_hold_valid", 32'(bus.core_valid), 1);
        chk("ref_hold_cmd",   32'(bus.core_cmd), 32'(CMD_REF));
        bus.core_ready = 1'b1;
        step();
        bus.core_ready = 1'b0;
        chk("ref_wait_valid", 32'(bus.core_valid), 0);
        chk("ref_wait_debt",  32'(bus.ref_debt), 1);
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        chk("ref_done_debt", 32'(bus.ref_debt), 0);

        // ---------------- write burst hits the word quantum ----------------
        start();
        bus.enable = 1'b1;
        bus.wr_req = 1'b1;
        step();
        chk("q_issue_valid", 32'(bus.core_valid), 1);
        chk("q_issue_cmd",   32'(bus.core_cmd), 32'(CMD_WR));
        bus.core_ready = 1'b1;
        step();
        bus.core_ready = 1'b0;
        chk("q_wr_grant", 32'(bus.wr_grant), 1);
        bus.core_word = 1'b1;
        stop_seen = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.core_stop) stop_seen = 1;
        end
        chk("q_stop_early", 32'(stop_seen), 0);
        step();
        chk("q_stop_rise", 32'(bus.core_stop), 1);
        bus.core_word = 1'b0;
        step();
        chk("q_stop_hold", 32'(bus.core_stop), 1);
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        chk("q_done_grant", 32'(bus.wr_grant), 0);
        chk("q_done_stop",  32'(bus.core_stop), 0);
        chk("q_idle_gap",   32'(bus.core_valid), 0);
        step();
        chk("q_reissue_valid", 32'(bus.core_valid), 1);
        chk("q_reissue_cmd",   32'(bus.core_cmd), 32'(CMD_WR));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("q_rst_mid_op", 32'(bus.core_valid), 0);

        // ---------------- read priority ----------------
        start();
        bus.enable  = 1'b1;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_prio = 1'b1;
        run_op(CMD_RD, "prio");

        // ---------------- starvation guard, then pending refresh ----------------
        start();
        bus.enable = 1'b1;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        run_op(CMD_WR,  "stv1");
        run_op(CMD_WR,  "stv2");
        run_op(CMD_WR,  "stv3");
        run_op(CMD_WR,  "stv4");
        run_op(CMD_RD,  "stv5");
        run_op(CMD_WR,  "stv6");
        run_op(CMD_REF, "stv7");
        chk("stv_debt", 32'(bus.ref_debt), 0);

        // ---------------- blocked read never offered; refreshes still run ----------------
        start();
        bus.enable     = 1'b1;
        bus.rd_req     = 1'b1;
        bus.rd_blocked = 1'b1;
        bus.core_ready = 1'b1;
        bad  = 0;
        refs = 0;
        hs   = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            bus.core_done = 1'b0;
            if (hs != 0) begin
                bus.core_done = 1'b1;
                hs = 0;
            end
            if (bus.core_valid) begin
                if (bus.core_cmd != CMD_REF) bad++;
                else refs++;
                hs = 1;
            end
        end
        chk("blk_non_ref", 32'(bad), 0);
        chk("blk_refs",    32'(refs), 6);

        // ---------------- refresh tick in the middle of a write burst ----------------
        start();
        bus.enable = 1'b1;
        bus.wr_req = 1'b1;
        step();
        bus.core_ready = 1'b1;
        step();
        bus.core_ready = 1'b0;
        bus.core_word  = 1'b1;
        repeat (3) step();
        bus.core_word = 1'b0;
        repeat (10) step();
        chk("rt_pre_stop", 32'(bus.core_stop), 0);
        chk("rt_pre_debt", 32'(bus.ref_debt), 0);
        step();
        chk("rt_debt",     32'(bus.ref_debt), 1);
        chk("rt_stop_lag", 32'(bus.core_stop), 0);
        step();
        chk("rt_stop", 32'(bus.core_stop), 1);
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        chk("rt_grant_clr", 32'(bus.wr_grant), 0);
        step();
        chk("rt_next_valid", 32'(bus.core_valid), 1);
        chk("rt_next_cmd",   32'(bus.core_cmd), 32'(CMD_REF));

        // ---------------- core stalls: debt saturates, overrun sticks ----------------
        start();
        bus.enable = 1'b1;
        repeat (48) step();
        chk("ov_debt3",     32'(bus.ref_debt), 3);
        chk("ov_pre",       32'(bus.ref_overrun), 0);
        chk("ov_stall_cmd", 32'({bus.core_valid, bus.core_cmd}), 32'({1'b1, CMD_REF}));
        repeat (16) step();
        chk("ov_set",       32'(bus.ref_overrun), 1);
        chk("ov_debt_sat",  32'(bus.ref_debt), 3);
        repeat (20) step();
        chk("ov_sticky", 32'(bus.ref_overrun), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ov_rst_clear", 32'(bus.ref_overrun), 0);
        chk("ov_rst_debt",  32'(bus.ref_debt), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
